// File: rtl/tb_sram_mp.sv
// tb_sram_mp -- multi-port, latency-configurable SRAM model for the test harness.
//
// NUM_PORTS request/grant ports share one word-addressed array with byte
// enables. A round-robin arbiter grants at most one port per cycle. Every
// accepted access (read or write) travels through a READ_LATENCY-deep
// response pipeline and pulses rvalid on the issuing port. Writes answer with
// zero data. An optional LFSR stalls all grants on cycles where its LSB is set.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset (array contents are kept)
//   req_i     per-port request
//   gnt_o     per-port grant, combinational, one-hot or zero
//   we_i      per-port write enable
//   addr_i    per-port word address, port p at [p*AW +: AW]
//   wdata_i   per-port write data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   be_i      per-port byte enables, port p at [p*DATA_WIDTH/8 +: DATA_WIDTH/8]
//   rvalid_o  per-port one-cycle response pulse (registered)
//   rdata_o   per-port response data, held between pulses (registered)
module tb_sram_mp #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_WORDS    = 32768,
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          STALL_RANDOM = 1'b0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned BW = DATA_WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            req_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*AW-1:0]         addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS*BW-1:0]         be_i,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [15:0]           lfsr_q;
  logic                  lfsr_fb;
  logic [PW-1:0]         rr_q;
  logic [PW-1:0]         gnt_idx;
  logic [PW:0]           cand;
  logic                  found;
  logic                  stall;
  logic                  accept;

  logic                  sel_we;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BW-1:0]         sel_be;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic                  vld_out;
  logic [PW-1:0]         port_out;
  logic [DATA_WIDTH-1:0] data_out;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign stall   = STALL_RANDOM && lfsr_q[0];

  // Round-robin search starting at rr_q, wrapping modulo NUM_PORTS
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      cand = {1'b0, rr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_PORTS)) cand = cand - (PW+1)'(NUM_PORTS);
      if (!found && req_i[cand[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  assign accept = found && !stall && !rst_i;

  always_comb begin
    gnt_o = '0;
    if (accept) gnt_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_we    = we_i[gnt_idx];
    sel_addr  = addr_i[gnt_idx*AW +: AW];
    sel_wdata = wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    sel_be    = be_i[gnt_idx*BW +: BW];
    // Extra bit so a power-of-two depth does not wrap the bound to zero
    in_range  = ({1'b0, sel_addr} < (AW+1)'(NUM_WORDS));
    // Writes and out-of-range reads answer with zero
    rd_word   = (!sel_we && in_range) ? mem[sel_addr] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
      rr_q   <= '0;
    end else begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
      if (accept) rr_q <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Array write at the grant edge; contents survive reset
  always_ff @(posedge clk_i) begin
    if (accept && sel_we && in_range) begin
      for (int b = 0; b < int'(BW); b++) begin
        if (sel_be[b]) mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // Stage boundary: grant edge -> READ_LATENCY-1 internal stages -> output register
  if (READ_LATENCY > 1) begin : g_pipe
    localparam int unsigned D = READ_LATENCY - 1;
    logic                  vld_p  [D];
    logic [PW-1:0]         port_p [D];
    logic [DATA_WIDTH-1:0] data_p [D];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(D); i++) vld_p[i] <= 1'b0;
      end else begin
        vld_p[0] <= accept;
        for (int i = 1; i < int'(D); i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      port_p[0] <= gnt_idx;
      data_p[0] <= rd_word;
      for (int i = 1; i < int'(D); i++) begin
        port_p[i] <= port_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end

    assign vld_out  = vld_p[D-1];
    assign port_out = port_p[D-1];
    assign data_out = data_p[D-1];
  end else begin : g_direct
    assign vld_out  = accept;
    assign port_out = gnt_idx;
    assign data_out = rd_word;
  end

  // Stage boundary: response delivery to the owning port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= '0;
      if (vld_out) begin
        rvalid_o[port_out]                          <= 1'b1;
        rdata_o[port_out*DATA_WIDTH +: DATA_WIDTH] <= data_out;
      end
    end
  end

endmodule

// File: tb/tb_tb_sram_mp.sv
// tb_tb_sram_mp -- directed self-checking bench for tb_sram_mp.
//
// Instance A: 3 ports, latency 3, 1000 words, no stall (latency, byte
// enables, out-of-range, round-robin). Instance B: 2 ports, latency 4,
// 128 words, random stall (stall behaviour, ordering, reset mid-flight).
module tb_tb_sram_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  // ---------------- instance A ----------------
  logic         rst_a;
  logic [2:0]   req_a, gnt_a, we_a, rvalid_a;
  logic [29:0]  addr_a;
  logic [191:0] wdata_a, rdata_a;
  logic [23:0]  be_a;

  tb_sram_mp #(
    .DATA_WIDTH(64), .NUM_WORDS(1000), .NUM_PORTS(3), .READ_LATENCY(3),
    .STALL_RANDOM(1'b0), .LFSR_SEED(16'hACE1)
  ) u_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .gnt_o(gnt_a), .we_i(we_a),
    .addr_i(addr_a), .wdata_i(wdata_a), .be_i(be_a),
    .rvalid_o(rvalid_a), .rdata_o(rdata_a)
  );

  // ---------------- instance B ----------------
  logic         rst_b;
  logic [1:0]   req_b, gnt_b, we_b, rvalid_b;
  logic [13:0]  addr_b;
  logic [127:0] wdata_b, rdata_b;
  logic [15:0]  be_b;

  tb_sram_mp #(
    .DATA_WIDTH(64), .NUM_WORDS(128), .NUM_PORTS(2), .READ_LATENCY(4),
    .STALL_RANDOM(1'b1), .LFSR_SEED(16'hACE1)
  ) u_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .gnt_o(gnt_b), .we_i(we_b),
    .addr_i(addr_b), .wdata_i(wdata_b), .be_i(be_b),
    .rvalid_o(rvalid_b), .rdata_o(rdata_b)
  );

  // Reference LFSR for instance B, x^16+x^14+x^13+x^11+1
  logic [15:0] lm = 16'hACE1;
  always @(posedge clk) begin
    if (rst_b) lm <= 16'hACE1;
    else       lm <= {lm[0] ^ lm[2] ^ lm[3] ^ lm[5], lm[15:1]};
  end

  int stall_viol = 0;
  int stall_seen = 0;
  int rd_cnt     = 0;
  int rd_bad     = 0;
  bit rd_collect = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (lm[0] && gnt_b != 2'b00) stall_viol++;
    if (lm[0] && !rst_b && req_b != 2'b00) stall_seen++;
    if (rd_collect && rvalid_b[0]) begin
      if (rdata_b[63:0] != 64'(rd_cnt)) rd_bad++;
      rd_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Single-requestor transaction on instance A with latency and data check
  task automatic a_txn(input int p, input logic we, input logic [9:0] addr,
                       input logic [63:0] wd, input logic [7:0] be,
                       input logic [63:0] exp, input string tag);
    int k;
    @(negedge clk);
    req_a[p] = 1'b1;
    we_a[p]  = we;
    addr_a[p*10 +: 10]  = addr;
    wdata_a[p*64 +: 64] = wd;
    be_a[p*8 +: 8]      = be;
    #1;
    k = 0;
    while (!gnt_a[p] && k < 10) begin @(negedge clk); #1; k++; end
    chk({tag, "_gnt"}, gnt_a, 3'b001 << p);
    @(negedge clk);
    req_a[p] = 1'b0;
    we_a[p]  = 1'b0;
    k = 1;
    while (!rvalid_a[p] && k < 10) begin @(negedge clk); k++; end
    chk({tag, "_lat"}, k, 3);
    chk({tag, "_data"}, rdata_a[p*64 +: 64], exp);
  endtask

  // Port-0 request on instance B; returns at the negedge after acceptance
  task automatic b_issue(input logic we, input logic [6:0] addr, input logic [63:0] wd);
    int k;
    req_b[0]      = 1'b1;
    we_b[0]       = we;
    addr_b[6:0]   = addr;
    wdata_b[63:0] = wd;
    be_b[7:0]     = 8'hFF;
    #1;
    k = 0;
    while (!gnt_b[0] && k < 50) begin @(negedge clk); #1; k++; end
    if (!gnt_b[0]) chk("b_gnt_timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  int rr_cnt [3];
  int rr_bad;
  logic [63:0] rr_exp [3];
  int n, k, post;
  logic [1:0] g;

  initial begin
    rst_a = 1'b1; req_a = 3'b111; we_a = '0; addr_a = '0; wdata_a = '0; be_a = '0;
    rst_b = 1'b1; req_b = 2'b11;  we_b = '0; addr_b = '0; wdata_b = '0; be_b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt_a",    gnt_a,    0);
    chk("rst_gnt_b",    gnt_b,    0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    chk("rst_rdata_a",  rdata_a,  0);
    chk("rst_rdata_b",  rdata_b,  0);
    @(negedge clk);
    req_a = '0; req_b = '0; rst_a = 1'b0; rst_b = 1'b0;

    // Write then read, latency 3
    a_txn(0, 1'b1, 10'd5, 64'hDEAD_BEEF_0000_0539, 8'hFF, 64'h0, "wr5");
    a_txn(0, 1'b0, 10'd5, 64'h0, 8'h00, 64'hDEAD_BEEF_0000_0539, "rd5");
    @(negedge clk);
    chk("hold_rvalid", rvalid_a, 0);
    chk("hold_rdata",  rdata_a[63:0], 64'hDEAD_BEEF_0000_0539);

    // Byte enables on port 1
    a_txn(1, 1'b1, 10'd7, 64'h1111_1111_1111_1111, 8'hFF, 64'h0, "pre7");
    a_txn(1, 1'b1, 10'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, "be7");
    a_txn(1, 1'b0, 10'd7, 64'h0, 8'h00, 64'h1111_1111_FFFF_FFFF, "rd7");

    // Out-of-range on port 2
    a_txn(2, 1'b1, 10'd999,  64'h0999_0999_0999_0999, 8'hFF, 64'h0, "wr999");
    a_txn(2, 1'b1, 10'd1000, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 64'h0, "wr1000");
    a_txn(2, 1'b0, 10'd1000, 64'h0, 8'h00, 64'h0, "rd1000");
    a_txn(2, 1'b0, 10'd999,  64'h0, 8'h00, 64'h0999_0999_0999_0999, "rd999");

    // Round-robin fairness from reset
    rr_exp[0] = 64'hA0A0_0000_0000_0020;
    rr_exp[1] = 64'hA1A1_0000_0000_0021;
    rr_exp[2] = 64'hA2A2_0000_0000_0022;
    for (int p = 0; p < 3; p++)
      a_txn(p, 1'b1, 10'(20 + p), rr_exp[p], 8'hFF, 64'h0, "rrpre");
    @(negedge clk);
    rst_a  = 1'b1;
    req_a  = 3'b111;
    we_a   = '0;
    addr_a = {10'd22, 10'd21, 10'd20};
    #1;
    chk("rr_rst_gnt", gnt_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("rr_rst_rdata", rdata_a, 0);
    rr_bad = 0;
    for (int p = 0; p < 3; p++) rr_cnt[p] = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c == 6) req_a = '0;
        #1;
      end
      if (c < 6) chk("rr_gnt", gnt_a, 3'b001 << (c % 3));
      for (int p = 0; p < 3; p++) begin
        if (rvalid_a[p]) begin
          rr_cnt[p]++;
          if (rdata_a[p*64 +: 64] !== rr_exp[p]) rr_bad++;
        end
      end
    end
    chk("rr_cnt0", rr_cnt[0], 2);
    chk("rr_cnt1", rr_cnt[1], 2);
    chk("rr_cnt2", rr_cnt[2], 2);
    chk("rr_data", rr_bad, 0);

    // Random stall: preload 0..99 with value = address, then read back
    @(negedge clk);
    for (int a = 0; a < 100; a++) b_issue(1'b1, 7'(a), 64'(a));
    req_b[0] = 1'b0; we_b[0] = 1'b0;
    repeat (10) @(negedge clk);
    rd_collect = 1'b1;
    for (int a = 0; a < 100; a++) b_issue(1'b0, 7'(a), 64'h0);
    req_b[0] = 1'b0;
    repeat (12) @(negedge clk);
    rd_collect = 1'b0;
    chk("stall_rvalid_cnt", rd_cnt, 100);
    chk("stall_order",      rd_bad, 0);
    chk("stall_viol",       stall_viol, 0);
    chk("stall_seen",       stall_seen != 0, 1'b1);

    // Reset mid-flight, latency 4
    @(negedge clk);
    req_b  = 2'b11;
    we_b   = 2'b00;
    addr_b = {7'd11, 7'd10};
    #1;
    n = 0; k = 0;
    while (n < 2 && k < 60) begin
      g = gnt_b;
      if (g != 2'b00) n++;
      @(negedge clk);
      req_b = req_b & ~g;
      #1;
      k++;
    end
    chk("mid_grants", n, 2);
    req_b = 2'b00;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid_b, 0);
    chk("mid_rst_rdata",  rdata_b,  0);
    post = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (rvalid_b != 2'b00) post++;
    end
    chk("mid_no_rvalid", post, 0);
    req_b = 2'b11;
    #1;
    k = 0;
    while (gnt_b == 2'b00 && k < 50) begin @(negedge clk); #1; k++; end
    chk("mid_next_gnt", gnt_b, 2'b01);
    @(negedge clk);
    req_b = 2'b00;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
